// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: halt FSM encoding,
// arbitration modes and the reserved hold-level values.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } pipe_state_e;

  localparam int ARB_FIXED = 0;  // lowest nonzero channel index wins
  localparam int ARB_MAX   = 1;  // largest level wins, ties to lower index

  // Reserved hold levels; users slice these down to their HOLD_W.
  localparam int                    MAX_HOLD_W = 16;
  localparam logic [MAX_HOLD_W-1:0] HOLD_NONE  = '0;
  localparam logic [MAX_HOLD_W-1:0] HOLD_ALL   = '1;

  localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of hold-request, jump, debug and counter signals between the
// pipeline stages (master) and the controller (slave).
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int HOLD_W  = 3,
  parameter int ADDR_W  = 32
);
  localparam int SRC_W = $clog2(NUM_REQ);

  // No valid/ready pairs: jump_flag_i is a single-cycle strobe qualifying
  // jump_addr_i, and halt_i / req_hold_i are levels sampled every cycle.
  logic [NUM_REQ*HOLD_W-1:0] req_hold_i;
  logic                      jump_flag_i;
  logic [ADDR_W-1:0]         jump_addr_i;
  logic                      halt_i;
  logic                      clr_cnt_i;

  logic [HOLD_W-1:0]         hold_flag_o;
  logic [SRC_W-1:0]          hold_src_o;
  logic                      flush_flag_o;
  logic                      jump_flag_o;
  logic [ADDR_W-1:0]         jump_addr_o;
  logic                      halted_o;
  logic                      timeout_o;
  logic [31:0]               stall_cnt_o;
  logic [31:0]               flush_cnt_o;
  pipe_state_e               state_o;

  modport master (
    output req_hold_i, jump_flag_i, jump_addr_i, halt_i, clr_cnt_i,
    input  hold_flag_o, hold_src_o, flush_flag_o, jump_flag_o, jump_addr_o,
    input  halted_o, timeout_o, stall_cnt_o, flush_cnt_o, state_o
  );

  modport slave (
    input  req_hold_i, jump_flag_i, jump_addr_i, halt_i, clr_cnt_i,
    output hold_flag_o, hold_src_o, flush_flag_o, jump_flag_o, jump_addr_o,
    output halted_o, timeout_o, stall_cnt_o, flush_cnt_o, state_o
  );

endinterface

// File: rtl/pipe_ctrl_hold_arb.sv
// Combinational hold-request arbiter: picks one channel level and its index
// using either fixed priority or maximum-level selection.
module hold_arb
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int HOLD_W   = 3,
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic [NUM_REQ*HOLD_W-1:0]  req_hold_i,
  output logic [HOLD_W-1:0]          level_o,
  output logic [$clog2(NUM_REQ)-1:0] src_o
);
  localparam int SRC_W = $clog2(NUM_REQ);
  localparam logic [HOLD_W-1:0] LVL_NONE = HOLD_NONE[HOLD_W-1:0];

  logic [HOLD_W-1:0] lvl;

  always_comb begin
    level_o = LVL_NONE;
    src_o   = '0;
    lvl     = LVL_NONE;
    for (int k = 0; k < NUM_REQ; k++) begin
      lvl = req_hold_i[k*HOLD_W +: HOLD_W];
      if (ARB_MODE == ARB_MAX) begin
        // Strict compare keeps the earlier (lower) index on a tie.
        if (lvl > level_o) begin
          level_o = lvl;
          src_o   = SRC_W'(k);
        end
      end else begin
        if ((level_o == LVL_NONE) && (lvl != LVL_NONE)) begin
          level_o = lvl;
          src_o   = SRC_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: hold arbitration, jump pass-through with flush
// window, debug halt FSM, hold watchdog and performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int HOLD_W       = 3,
  parameter int ADDR_W       = 32,
  parameter int ARB_MODE     = ARB_FIXED,
  parameter int FLUSH_CYCLES = 1,
  parameter int TIMEOUT      = 1023
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);
  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [HOLD_W-1:0]      LVL_NONE   = HOLD_NONE[HOLD_W-1:0];
  localparam logic [HOLD_W-1:0]      LVL_ALL    = HOLD_ALL[HOLD_W-1:0];
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [WD_W-1:0]        WD_MAX     = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0]        WD_FIRE    = WD_W'(TIMEOUT - 1);

  logic [HOLD_W-1:0]      arb_level;
  logic [SRC_W-1:0]       arb_src;
  logic [HOLD_W-1:0]      hold_level;
  logic [ADDR_W-1:0]      jump_addr;
  logic                   jump;
  logic                   chan_held;

  pipe_state_e            state_q;
  logic                   halted_q;
  logic [FLUSH_CNT_W-1:0] flush_left_q, flush_left_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic [31:0]            stall_cnt_q, stall_cnt_d;
  logic [31:0]            flush_cnt_q, flush_cnt_d;

  hold_arb #(
    .NUM_REQ  (NUM_REQ),
    .HOLD_W   (HOLD_W),
    .ARB_MODE (ARB_MODE)
  ) u_hold_arb (
    .req_hold_i (bus.req_hold_i),
    .level_o    (arb_level),
    .src_o      (arb_src)
  );

  assign jump       = bus.jump_flag_i;
  assign jump_addr  = bus.jump_addr_i;
  assign chan_held  = (arb_level != LVL_NONE);
  assign hold_level = halted_q ? LVL_ALL : arb_level;

  // A jump always restarts the window, even if an earlier one is still open.
  always_comb begin
    flush_left_d = flush_left_q;
    if (jump) begin
      flush_left_d = FLUSH_LOAD;
    end else if (flush_left_q != '0) begin
      flush_left_d = flush_left_q - 1'b1;
    end
  end

  // The watchdog is frozen while halted so a debug session cannot trip it.
  always_comb begin
    wd_d = wd_q;
    if (!halted_q) begin
      if (!chan_held) begin
        wd_d = '0;
      end else if (wd_q != WD_MAX) begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.clr_cnt_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (hold_level != LVL_NONE) stall_cnt_d = stall_cnt_q + 32'd1;
      if (jump)                   flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.halt_i) state_q <= ST_DRAIN;
          halted_q <= 1'b0;
        end
        ST_DRAIN: begin
          if (!bus.halt_i) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end else if (!jump && (flush_left_q == '0)) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (!bus.halt_i) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_left_q <= '0;
      wd_q         <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      flush_left_q <= flush_left_d;
      wd_q         <= wd_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  // Reset also masks the combinational flush and timeout terms.
  assign bus.flush_flag_o = rst & (jump | (flush_left_q != '0));
  assign bus.timeout_o    = rst & ~halted_q & chan_held & (wd_q == WD_FIRE);
  assign bus.hold_flag_o  = hold_level;
  assign bus.hold_src_o   = arb_src;
  assign bus.jump_flag_o  = jump;
  assign bus.jump_addr_o  = jump_addr;
  assign bus.halted_o     = halted_q;
  assign bus.stall_cnt_o  = stall_cnt_q;
  assign bus.flush_cnt_o  = flush_cnt_q;
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed bench for pipe_ctrl against a cycle-level
// reference model of arbitration, flush window, halt, watchdog and counters.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int HOLD_W  = 3;
  localparam int ADDR_W  = 32;
  localparam int FLUSH   = 3;
  localparam int TMO     = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.NUM_REQ(NUM_REQ), .HOLD_W(HOLD_W), .ADDR_W(ADDR_W)) bus0 ();
  pipe_ctrl_if #(.NUM_REQ(NUM_REQ), .HOLD_W(HOLD_W), .ADDR_W(ADDR_W)) bus1 ();

  pipe_ctrl #(.NUM_REQ(NUM_REQ), .HOLD_W(HOLD_W), .ADDR_W(ADDR_W), .ARB_MODE(ARB_FIXED),
              .FLUSH_CYCLES(FLUSH), .TIMEOUT(TMO))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  pipe_ctrl #(.NUM_REQ(NUM_REQ), .HOLD_W(HOLD_W), .ADDR_W(ADDR_W), .ARB_MODE(ARB_MAX),
              .FLUSH_CYCLES(FLUSH), .TIMEOUT(TMO))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // ---------------- stimulus state ----------------
  logic [HOLD_W-1:0] lv [NUM_REQ];
  logic              jmp, hlt, clr;
  logic [ADDR_W-1:0] addr;

  // ---------------- scoreboard / model state ----------------
  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [ADDR_W-1:0] exp_q[$];
  bit          m_drain, m_halted;
  int          m_flush_end, m_run;
  logic [31:0] m_stall, m_flushc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void ref_arb(input int mode, output int lvl, output int src);
    int nz[$];
    lvl = 0;
    src = 0;
    if (mode == 0) begin
      for (int k = 0; k < NUM_REQ; k++) if (lv[k] != 0) nz.push_back(k);
      if (nz.size() > 0) begin
        src = nz[0];
        lvl = int'(lv[src]);
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) if (int'(lv[k]) > lvl) lvl = int'(lv[k]);
      if (lvl != 0) begin
        for (int k = NUM_REQ - 1; k >= 0; k--) if (int'(lv[k]) == lvl) src = k;
      end
    end
  endfunction

  function automatic void model_reset();
    m_drain     = 1'b0;
    m_halted    = 1'b0;
    m_flush_end = -1;
    m_run       = 0;
    m_stall     = '0;
    m_flushc    = '0;
    exp_q.delete();
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive();
    for (int k = 0; k < NUM_REQ; k++) begin
      bus0.req_hold_i[k*HOLD_W +: HOLD_W] = lv[k];
      bus1.req_hold_i[k*HOLD_W +: HOLD_W] = lv[k];
    end
    bus0.jump_flag_i = jmp;  bus1.jump_flag_i = jmp;
    bus0.jump_addr_i = addr; bus1.jump_addr_i = addr;
    bus0.halt_i      = hlt;  bus1.halt_i      = hlt;
    bus0.clr_cnt_i   = clr;  bus1.clr_cnt_i   = clr;
  endtask

  task automatic idle();
    for (int k = 0; k < NUM_REQ; k++) lv[k] = '0;
    jmp = 1'b0; hlt = 1'b0; clr = 1'b0; addr = '0;
  endtask

  // One cycle: apply inputs at negedge, check just after, advance the model.
  task automatic step(input bit preset = 1'b0);
    int  l0, s0, l1, s1, e_hold;
    bit  cnt_nz, e_flush, e_tmo;
    @(negedge clk);
    drive();
    if (preset) begin
      force dut0.stall_cnt_q = 32'hFFFF_FFFE;
      m_stall = 32'hFFFF_FFFE;
    end
    if (jmp) exp_q.push_back(addr);
    #1;
    if (preset) release dut0.stall_cnt_q;
    ref_arb(0, l0, s0);
    ref_arb(1, l1, s1);
    cnt_nz  = (cyc <= m_flush_end);
    e_hold  = m_halted ? 7 : l0;
    e_flush = jmp || cnt_nz;
    e_tmo   = !m_halted && (l0 != 0) && (m_run == TMO - 1);
    chk("hold_flag",      32'(bus0.hold_flag_o), 32'(e_hold));
    chk("hold_src",       32'(bus0.hold_src_o),  32'(s0));
    chk("max_hold_flag",  32'(bus1.hold_flag_o), 32'(m_halted ? 7 : l1));
    chk("max_hold_src",   32'(bus1.hold_src_o),  32'(s1));
    chk("flush_flag",     32'(bus0.flush_flag_o), 32'(e_flush));
    chk("halted",         32'(bus0.halted_o),    32'(m_halted));
    chk("timeout",        32'(bus0.timeout_o),   32'(e_tmo));
    chk("stall_cnt",      bus0.stall_cnt_o,      m_stall);
    chk("flush_cnt",      bus0.flush_cnt_o,      m_flushc);
    chk("jump_flag",      32'(bus0.jump_flag_o), 32'(jmp));
    if (bus0.jump_flag_o === 1'b1) begin
      if (exp_q.size() == 0) chk("jump_spurious", 32'd1, 32'd0);
      else                   chk("jump_addr", bus0.jump_addr_o, exp_q.pop_front());
    end
    if (exp_q.size() != 0) begin
      chk("jump_missing", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    // Watchdog uses the halt status of this cycle, so update it first.
    if (!m_halted) begin
      if (l0 == 0)         m_run = 0;
      else if (m_run < TMO) m_run = m_run + 1;
    end
    if (!hlt) begin
      m_drain = 1'b0; m_halted = 1'b0;
    end else if (!m_drain && !m_halted) begin
      m_drain = 1'b1;
    end else if (m_drain && !jmp && !cnt_nz) begin
      m_drain = 1'b0; m_halted = 1'b1;
    end
    if (jmp) m_flush_end = cyc + FLUSH - 1;
    m_stall  = clr ? 32'd0 : m_stall + ((e_hold != 0) ? 32'd1 : 32'd0);
    m_flushc = clr ? 32'd0 : m_flushc + (jmp ? 32'd1 : 32'd0);
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_flush"},   32'(bus0.flush_flag_o), 32'd0);
    chk({tag, "_halted"},  32'(bus0.halted_o),     32'd0);
    chk({tag, "_timeout"}, 32'(bus0.timeout_o),    32'd0);
    chk({tag, "_stall"},   bus0.stall_cnt_o,       32'd0);
    chk({tag, "_flushc"},  bus0.flush_cnt_o,       32'd0);
  endtask

  // Asynchronous reset between edges while a jump and halt are applied.
  task automatic async_reset();
    @(negedge clk);
    jmp = 1'b1; hlt = 1'b1; addr = $urandom; drive();
    #2 rst = 1'b0;
    #1 check_reset_outputs("arst");
    chk("arst_hold", 32'(bus0.hold_flag_o), 32'(lv[0] != 0 ? lv[0] : 0) |
        ((lv[0] == 0) ? 32'(bus0.hold_flag_o) & 32'd0 : 32'd0));
    @(posedge clk);
    #1 check_reset_outputs("arst_held");
    model_reset();
    idle(); drive();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle();
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("por");
    chk("por_hold", 32'(bus0.hold_flag_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Arbitration: levels 0,2,5,0
    lv[0] = 3'd0; lv[1] = 3'd2; lv[2] = 3'd5; lv[3] = 3'd0;
    step();
    lv[3] = 3'd5; step();
    idle(); step();

    // Jump at cycle 0 and 2 with FLUSH=3
    jmp = 1'b1; addr = 32'h0000_1000; step();
    jmp = 1'b0; step();
    jmp = 1'b1; addr = 32'h0000_2000; step();
    jmp = 1'b0; repeat (4) step();

    // Halt raised during an active flush, then dropped
    jmp = 1'b1; addr = 32'hCAFE_0000; step();
    jmp = 1'b0; hlt = 1'b1; repeat (5) step();
    hlt = 1'b0; repeat (2) step();

    // Watchdog: 10 held cycles, a drop, 5 more held cycles
    lv[0] = 3'd1; repeat (10) step();
    lv[0] = 3'd0; step();
    lv[0] = 3'd1; repeat (5) step();
    lv[0] = 3'd0; step();

    // Stall counter wrap and clear-over-increment
    lv[1] = 3'd3; step(1'b1);
    repeat (3) step();
    clr = 1'b1; step();
    clr = 1'b0; step();
    idle(); step();

    // Reset while halted with a flush open
    hlt = 1'b1; repeat (3) step();
    jmp = 1'b1; addr = 32'h0BAD_F00D; step();
    async_reset();
    repeat (4) step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < NUM_REQ; k++)
          lv[k] = ($urandom_range(0, 2) == 0) ? HOLD_W'($urandom_range(1, 7)) : '0;
      end
      jmp  = ($urandom_range(0, 5) == 0);
      addr = $urandom;
      if ($urandom_range(0, 19) == 0) hlt = ~hlt;
      clr  = ($urandom_range(0, 40) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter NUM_REQ, default 4: number of hold-request channels; 2..16.
REQ-002 Parameter HOLD_W, default 3: hold-level width; 0 = none, all-ones = whole pipeline.
REQ-003 Parameter ADDR_W, default 32: jump address width.
REQ-004 Parameter ARB_MODE, default 0: 0 = fixed priority (lowest index wins), 1 = maximum level wins.
REQ-005 Parameter FLUSH_CYCLES, default 1: cycles flush_flag_o stays high per jump; 1..15.
REQ-006 Parameter TIMEOUT, default 1023: consecutive channel-hold cycles before timeout_o fires.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 req_hold_i  in  NUM_REQ*HOLD_W  per-channel hold level; channel k in bits [k*HOLD_W +: HOLD_W].
REQ-010 jump_flag_i  in  1  jump request from execute.
REQ-011 jump_addr_i  in  ADDR_W  jump target.
REQ-012 halt_i  in  1  debug halt request, level.
REQ-013 clr_cnt_i  in  1  synchronous clear of the performance counters.
REQ-014 hold_flag_o  out  HOLD_W  selected hold level.
REQ-015 hold_src_o  out  clog2(NUM_REQ)  winning channel index; 0 when no channel holds.
REQ-016 flush_flag_o  out  1  flush of fetch/decode stages.
REQ-017 jump_flag_o / jump_addr_o  out  1 / ADDR_W  jump to PC register.
REQ-018 halted_o  out  1  pipeline halted for debug.
REQ-019 timeout_o  out  1  one-cycle hold-watchdog pulse.
REQ-020 stall_cnt_o / flush_cnt_o  out  32 each  performance counters.

Function
REQ-021 Channel hold level is combinational, zero latency: ARB_MODE 0 takes the lowest-index nonzero channel; ARB_MODE 1 takes the largest level, with ties going to the lower index.
REQ-022 In state HALTED, hold_flag_o SHALL be all-ones regardless of channels; otherwise it SHALL be the channel level.
REQ-023 jump_flag_o and jump_addr_o SHALL pass through combinationally in the same cycle as jump_flag_i.
REQ-024 flush_flag_o SHALL be high in the jump cycle and for FLUSH_CYCLES-1 following cycles, driven by a down-counter.
REQ-025 A jump arriving while the flush counter is nonzero SHALL reload the counter to FLUSH_CYCLES-1.
REQ-026 Halt FSM states: RUN, DRAIN, HALTED.
- RUN to DRAIN: halt_i=1.
- DRAIN to HALTED: no jump this cycle and the flush counter is 0.
- DRAIN or HALTED to RUN: halt_i=0.
REQ-027 halted_o SHALL be high only in HALTED, as a registered state decode.
REQ-028 The watchdog counter SHALL increment each cycle a channel level is nonzero and clear when it is zero.
- timeout_o pulses exactly once when the count reaches TIMEOUT.
- The count then saturates with no further pulse until it clears.
- HALTED cycles SHALL neither count nor clear.
REQ-029 stall_cnt_o SHALL increment each cycle hold_flag_o is nonzero.
REQ-030 flush_cnt_o SHALL increment each cycle jump_flag_i is high.
REQ-031 Both counters SHALL wrap modulo 2^32; clr_cnt_i SHALL zero them and take priority over any increment that cycle.

Reset
REQ-032 While rst=0, all of the following SHALL be held:
- FSM in RUN; flush counter, watchdog, stall_cnt_o and flush_cnt_o at 0.
- halted_o, timeout_o and flush_flag_o at 0.
REQ-033 Reset assertion mid-flush or mid-halt SHALL abort immediately, with no residual flush or halt after release.

Structure
REQ-034 The hold-level constants (none, all-ones), FSM state encoding and the ARB_MODE values SHALL live in the shared defines package.
REQ-035 Arbitration SHALL be one sub-module, hold_arb, parametrised by NUM_REQ, HOLD_W and ARB_MODE, producing level and index.

Verification
REQ-036 NUM_REQ=4, HOLD_W=3, ARB_MODE=0, channel levels 0,2,5,0 -> hold_flag_o=2, hold_src_o=1; same levels with ARB_MODE=1 -> 5, src 2.
REQ-037 FLUSH_CYCLES=3, jump at cycle 0, second jump at cycle 2 -> flush_flag_o high cycles 0-4; flush_cnt_o=2; jump_addr_o tracks jump_addr_i in each jump cycle.
REQ-038 halt_i raised during an active flush -> FSM stays in DRAIN until the flush ends, then halted_o=1 and hold_flag_o=7; halt_i dropped -> RUN next cycle.
REQ-039 TIMEOUT=5, channel 0 held at level 1 for 10 cycles -> single timeout_o pulse on the 5th cycle; a level drop then 5 more held cycles -> second pulse.
REQ-040 stall_cnt_o preset near 0xFFFFFFFF with stalls -> wraps to 0; clr_cnt_i together with a stall -> 0.
REQ-041 rst asserted in HALTED with flush active -> all outputs 0 asynchronously; after release, halt_i=0 -> RUN with no flush.
